// File: rtl/vga_idx_pkg.sv
// Shared constants and the queued-pixel entry type for vga_idx_write_queue.
package vga_idx_pkg;

  localparam int FB_WORDS_DEF = 307200;
  localparam int IDX_ADDR_W   = 19;
  localparam int IDX_DATA_W   = 8;

  localparam int STAT_DROP_LSB = 16;
  localparam int STAT_OVF      = 15;
  localparam int STAT_FULL     = 14;
  localparam int STAT_EMPTY    = 13;

  typedef struct packed {
    logic [IDX_ADDR_W-1:0] addr;
    logic [IDX_DATA_W-1:0] data;
  } idx_entry_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/vga_idx_write_queue_fifo.sv
// Single-clock FIFO with count-based full/empty; a push while full is
// accepted when a pop happens in the same cycle.
module idx_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 27
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       pop_i,
  output logic                       push_ok_o,
  output logic                       pop_ok_o,
  output logic [W-1:0]               head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign head_o    = mem_q[rd_ptr_q];
  assign pop_ok    = pop_i && !empty_o;
  assign push_ok   = push_i && (!full_o || pop_ok);
  assign push_ok_o = push_ok;
  assign pop_ok_o  = pop_ok;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/vga_idx_write_queue.sv
// Queues processor framebuffer stores and replays them to the VGA index RAM.
// Define VGA_IDX_BLANK_ONLY_EN to restrict draining to the blanking interval.
module vga_idx_write_queue
  import vga_idx_pkg::*;
#(
  parameter logic [31:0] FB_BASE     = 32'h0001_0000,
  parameter int          FB_WORDS    = FB_WORDS_DEF,
  parameter logic [31:0] STATUS_ADDR = 32'h0000_FFFC,
  parameter int          DEPTH       = 16,
  parameter int          ADDR_W      = IDX_ADDR_W,
  parameter int          DATA_W      = IDX_DATA_W
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [31:0]       iMEM_ADDR,
  input  logic [31:0]       iMEM_WDATA,
  input  logic              iMEM_WE,
  output logic [31:0]       oMEM_RDATA,
  input  logic              iBLANK_n,
  output logic [ADDR_W-1:0] oIDX_ADDR,
  output logic [DATA_W-1:0] oIDX_DATA,
  output logic              oIDX_WE,
  output logic              oFULL
);

  localparam logic [31:0] FB_END = FB_BASE + 32'(FB_WORDS);
  localparam int          CNT_W  = $clog2(DEPTH+1);
  localparam int          ENT_W  = $bits(idx_entry_t);

  logic [31:0]       offset;
  logic              win_hit, stat_clr, drain_en;
  logic              push_ok, pop_ok, fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  idx_entry_t        push_entry, head_entry;
  logic [31:0]       status;
  logic              unused_bits;

  logic [31:0]       rdata_q, rdata_d;
  logic [ADDR_W-1:0] idx_addr_q, idx_addr_d;
  logic [DATA_W-1:0] idx_data_q, idx_data_d;
  logic              idx_we_q, idx_we_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic              ovf_q, ovf_d;

  assign offset   = iMEM_ADDR - FB_BASE;
  assign win_hit  = iMEM_WE && (iMEM_ADDR >= FB_BASE) && (iMEM_ADDR < FB_END);
  assign stat_clr = iMEM_WE && (iMEM_ADDR == STATUS_ADDR) && iMEM_WDATA[0];

  assign push_entry.addr = offset[IDX_ADDR_W-1:0];
  assign push_entry.data = iMEM_WDATA[IDX_DATA_W-1:0];

`ifdef VGA_IDX_BLANK_ONLY_EN
  assign drain_en    = ~iBLANK_n;
  assign unused_bits = ^{offset[31:IDX_ADDR_W], iMEM_WDATA[31:IDX_DATA_W]};
`else
  assign drain_en    = 1'b1;
  assign unused_bits = ^{offset[31:IDX_ADDR_W], iMEM_WDATA[31:IDX_DATA_W], iBLANK_n};
`endif

  idx_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk_i     (iCLK),
    .rst_i     (iRST),
    .push_i    (win_hit),
    .wdata_i   (push_entry),
    .pop_i     (drain_en),
    .push_ok_o (push_ok),
    .pop_ok_o  (pop_ok),
    .head_o    (head_entry),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  // Built purely from registered state, so a read sees the pre-push/pop view.
  always_comb begin
    status                            = '0;
    status[STAT_DROP_LSB +: 16]       = drop_cnt_q;
    status[STAT_OVF]                  = ovf_q;
    status[STAT_FULL]                 = fifo_full;
    status[STAT_EMPTY]                = fifo_empty;
    status[4:0]                       = 5'(fifo_count);
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    ovf_d      = ovf_q;
    idx_we_d   = pop_ok;
    idx_addr_d = idx_addr_q;
    idx_data_d = idx_data_q;
    rdata_d    = (iMEM_ADDR == STATUS_ADDR) ? status : 32'h0;
    if (stat_clr) begin
      drop_cnt_d = '0;
      ovf_d      = 1'b0;
    end else if (win_hit && !push_ok) begin
      drop_cnt_d = sat_inc16(drop_cnt_q);
      ovf_d      = 1'b1;
    end
    if (pop_ok) begin
      idx_addr_d = ADDR_W'(head_entry.addr);
      idx_data_d = DATA_W'(head_entry.data);
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      rdata_q    <= '0;
      idx_addr_q <= '0;
      idx_data_q <= '0;
      idx_we_q   <= 1'b0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      rdata_q    <= rdata_d;
      idx_addr_q <= idx_addr_d;
      idx_data_q <= idx_data_d;
      idx_we_q   <= idx_we_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign oMEM_RDATA = rdata_q;
  assign oIDX_ADDR  = idx_addr_q;
  assign oIDX_DATA  = idx_data_q;
  assign oIDX_WE    = idx_we_q;
  assign oFULL      = fifo_full;

endmodule

// File: tb/tb_vga_idx_write_queue.sv
// Directed bench for vga_idx_write_queue; expectations follow the build's
// VGA_IDX_BLANK_ONLY_EN setting.
module tb_vga_idx_write_queue;

  localparam logic [31:0] FB_BASE     = 32'h0001_0000;
  localparam int          FB_WORDS    = 307200;
  localparam logic [31:0] FB_END      = FB_BASE + 32'(FB_WORDS);
  localparam logic [31:0] STATUS_ADDR = 32'h0000_FFFC;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [31:0] iMEM_ADDR;
  logic [31:0] iMEM_WDATA;
  logic        iMEM_WE;
  logic [31:0] oMEM_RDATA;
  logic        iBLANK_n;
  logic [18:0] oIDX_ADDR;
  logic [7:0]  oIDX_DATA;
  logic        oIDX_WE;
  logic        oFULL;

  int n_assert = 0;
  int n_fail   = 0;
  int we_cnt;

  vga_idx_write_queue dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iMEM_ADDR  (iMEM_ADDR),
    .iMEM_WDATA (iMEM_WDATA),
    .iMEM_WE    (iMEM_WE),
    .oMEM_RDATA (oMEM_RDATA),
    .iBLANK_n   (iBLANK_n),
    .oIDX_ADDR  (oIDX_ADDR),
    .oIDX_DATA  (oIDX_DATA),
    .oIDX_WE    (oIDX_WE),
    .oFULL      (oFULL)
  );

  always #5 iCLK = ~iCLK;

  always @(negedge iCLK) begin
    if (!iRST && oIDX_WE)
      $display("idx write addr=%05h data=%02h", oIDX_ADDR, oIDX_DATA);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge iCLK);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    iMEM_ADDR  = a;
    iMEM_WDATA = d;
    iMEM_WE    = 1'b1;
    cyc();
    iMEM_WE    = 1'b0;
    iMEM_ADDR  = 32'h0;
  endtask

  initial begin
    iRST = 1'b1; iMEM_ADDR = 0; iMEM_WDATA = 0; iMEM_WE = 0; iBLANK_n = 1'b1;
    cyc(); cyc();
    chk("rst_rdata", oMEM_RDATA, 32'h0);
    chk("rst_we",    32'(oIDX_WE), 32'h0);
    chk("rst_addr",  32'(oIDX_ADDR), 32'h0);
    chk("rst_data",  32'(oIDX_DATA), 32'h0);
    chk("rst_full",  32'(oFULL), 32'h0);
    iRST = 1'b0;

    iMEM_ADDR = STATUS_ADDR;
    cyc();
    chk("idle_status", oMEM_RDATA, 32'h0000_2000);

    // single store, two-cycle latency to the index write
    iBLANK_n = 1'b0;
    store(FB_BASE + 5, 32'hFFFF_FF2A);
    chk("single_we_early", 32'(oIDX_WE), 32'h0);
    iMEM_ADDR = STATUS_ADDR;
    cyc();
    chk("single_we",     32'(oIDX_WE), 32'h1);
    chk("single_addr",   32'(oIDX_ADDR), 32'd5);
    chk("single_data",   32'(oIDX_DATA), 32'h2A);
    chk("status_cnt1",   oMEM_RDATA, 32'h0000_0001);
    iMEM_ADDR = 32'h0;
    cyc();
    chk("single_we_off", 32'(oIDX_WE), 32'h0);
    chk("nonstat_rdata", oMEM_RDATA, 32'h0);

    // three stores, strict order
    iBLANK_n = 1'b1;
`ifdef VGA_IDX_BLANK_ONLY_EN
    store(FB_BASE + 10, 32'h11);
    store(FB_BASE + 11, 32'h22);
    store(FB_BASE + 12, 32'h33);
    cyc();
    chk("blank_hold_we", 32'(oIDX_WE), 32'h0);
    iBLANK_n = 1'b0;
    cyc();
    chk("ord0_we", 32'(oIDX_WE), 32'h1);
    chk("ord0", {oIDX_ADDR, 5'b0, oIDX_DATA}, {19'd10, 5'b0, 8'h11});
    cyc();
    chk("ord1", {oIDX_WE, oIDX_ADDR, 4'b0, oIDX_DATA}, {1'b1, 19'd11, 4'b0, 8'h22});
    cyc();
    chk("ord2", {oIDX_WE, oIDX_ADDR, 4'b0, oIDX_DATA}, {1'b1, 19'd12, 4'b0, 8'h33});
    cyc();
    chk("ord_end_we", 32'(oIDX_WE), 32'h0);
`else
    store(FB_BASE + 10, 32'h11);
    chk("ord_first_we", 32'(oIDX_WE), 32'h0);
    store(FB_BASE + 11, 32'h22);
    chk("ord0", {oIDX_WE, oIDX_ADDR, 4'b0, oIDX_DATA}, {1'b1, 19'd10, 4'b0, 8'h11});
    store(FB_BASE + 12, 32'h33);
    chk("ord1", {oIDX_WE, oIDX_ADDR, 4'b0, oIDX_DATA}, {1'b1, 19'd11, 4'b0, 8'h22});
    cyc();
    chk("ord2", {oIDX_WE, oIDX_ADDR, 4'b0, oIDX_DATA}, {1'b1, 19'd12, 4'b0, 8'h33});
    cyc();
    chk("ord_end_we", 32'(oIDX_WE), 32'h0);
`endif

`ifdef VGA_IDX_BLANK_ONLY_EN
    // overflow: 18 stores into a 16-deep queue while not blanking
    iBLANK_n = 1'b1;
    for (int i = 0; i < 18; i++) store(FB_BASE + 100 + 32'(i), 32'(i));
    chk("ovf_full", 32'(oFULL), 32'h1);
    iMEM_ADDR = STATUS_ADDR;
    cyc();
    chk("ovf_status", oMEM_RDATA, 32'h0002_C010);
    store(STATUS_ADDR, 32'h1);
    chk("clr_read_old", oMEM_RDATA, 32'h0002_C010);
    iMEM_ADDR = STATUS_ADDR;
    cyc();
    chk("clr_status", oMEM_RDATA, 32'h0000_4010);

    // full queue, push and pop every cycle
    iBLANK_n = 1'b0;
    we_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      iMEM_ADDR = FB_BASE + 200 + 32'(i); iMEM_WDATA = 32'(i); iMEM_WE = 1'b1;
      cyc();
      if (oIDX_WE) we_cnt++;
    end
    iMEM_WE = 1'b0;
    chk("stream_writes", 32'(we_cnt), 32'd40);
    chk("stream_last",   {oIDX_ADDR, 5'b0, oIDX_DATA}, {19'd223, 5'b0, 8'd23});
    chk("stream_full",   32'(oFULL), 32'h1);
    we_cnt = 0;
    iMEM_ADDR = STATUS_ADDR;
    cyc();
    if (oIDX_WE) we_cnt++;
    chk("stream_status", oMEM_RDATA, 32'h0000_4010);
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (oIDX_WE) we_cnt++;
    end
    chk("drain_writes", 32'(we_cnt), 32'd16);
    chk("drain_full",   32'(oFULL), 32'h0);
`else
    we_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      iMEM_ADDR = FB_BASE + 200 + 32'(i); iMEM_WDATA = 32'(i); iMEM_WE = 1'b1;
      cyc();
      if (oIDX_WE) we_cnt++;
    end
    iMEM_WE = 1'b0;
    iMEM_ADDR = 32'h0;
    chk("stream_last", {oIDX_ADDR, 5'b0, oIDX_DATA}, {19'd238, 5'b0, 8'd38});
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (oIDX_WE) we_cnt++;
    end
    chk("stream_writes", 32'(we_cnt), 32'd40);
    chk("stream_full",   32'(oFULL), 32'h0);
    iMEM_ADDR = STATUS_ADDR;
    cyc();
    chk("stream_status", oMEM_RDATA, 32'h0000_2000);
`endif

    // window boundaries
    iBLANK_n = 1'b0;
    store(FB_END, 32'h55);
    store(FB_BASE - 1, 32'h66);
    iMEM_ADDR = STATUS_ADDR;
    cyc();
    chk("oob_status", oMEM_RDATA, 32'h0000_2000);
    chk("oob_we",     32'(oIDX_WE), 32'h0);
    store(FB_END - 1, 32'h77);
    cyc();
    chk("top_word", {oIDX_WE, oIDX_ADDR, 4'b0, oIDX_DATA}, {1'b1, 19'h4AFFF, 4'b0, 8'h77});
    cyc();

    // reset in the middle of a drain burst
`ifdef VGA_IDX_BLANK_ONLY_EN
    iBLANK_n = 1'b1;
    for (int i = 0; i < 5; i++) store(FB_BASE + 300 + 32'(i), 32'hA0 + 32'(i));
    iBLANK_n = 1'b0;
    cyc(); cyc();
`else
    for (int i = 0; i < 3; i++) store(FB_BASE + 300 + 32'(i), 32'hA0 + 32'(i));
`endif
    chk("burst_mid", {oIDX_WE, oIDX_ADDR, 4'b0, oIDX_DATA}, {1'b1, 19'd301, 4'b0, 8'hA1});
    iRST = 1'b1;
    #1;
    chk("async_rst_we",   32'(oIDX_WE), 32'h0);
    chk("async_rst_addr", 32'(oIDX_ADDR), 32'h0);
    cyc();
    iRST = 1'b0;
    we_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (oIDX_WE) we_cnt++;
    end
    chk("post_rst_writes", 32'(we_cnt), 32'd0);
    iMEM_ADDR = STATUS_ADDR;
    cyc();
    chk("post_rst_status", oMEM_RDATA, 32'h0000_2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_idx_write_queue.md
# vga_idx_write_queue

Bus responder between the processor's data-memory store port and the VGA controller's index-RAM write port. Captures processor stores addressed to the framebuffer window, buffers them in a small FIFO, and replays them to the index RAM only during VGA blanking, so that stores never tear the visible frame. Also exposes a status word that the processor can read back on its memory read-data path.

## Interface
- FB_BASE, 32'h0001_0000, first processor word address of the framebuffer window
- FB_WORDS, 307200, window size in words (640x480)
- STATUS_ADDR, 32'h0000_FFFC, processor address of the status/control word
- DEPTH, 16, FIFO entries; power of two, 2..16
- ADDR_W, 19, index-RAM address width
- DATA_W, 8, index-RAM data width (colour index)

Ports:
- iCLK  in  1  single clock (VGA control clock domain)
- iRST  in  1  reset; asynchronous, active-high
- iMEM_ADDR  in  32  processor store/load address
- iMEM_WDATA  in  32  processor store data; only [DATA_W-1:0] is used for pixels
- iMEM_WE  in  1  store strobe, one cycle per store
- oMEM_RDATA  out  32  registered read data (status word or 0)
- iBLANK_n  in  1  VGA blank, active-low (0 = blanking interval)
- oIDX_ADDR  out  ADDR_W  index-RAM write address
- oIDX_DATA  out  DATA_W  index-RAM write data
- oIDX_WE  out  1  index-RAM write enable, one cycle per pixel
- oFULL  out  1  FIFO full, combinational from the count register

## Operation
- Window hit: iMEM_WE=1 and FB_BASE <= iMEM_ADDR < FB_BASE+FB_WORDS. Pushes {iMEM_ADDR-FB_BASE truncated to ADDR_W, iMEM_WDATA[DATA_W-1:0]}.
- Push is accepted if count<DEPTH, or if a pop occurs in the same cycle.
- Otherwise the store is dropped:
  - drop_cnt increments, saturating at 16'hFFFF.
  - Sticky ovf sets.
- A store to STATUS_ADDR with iMEM_WDATA[0]=1 clears drop_cnt and ovf. Other bits are ignored.
- Stores outside the window and not at STATUS_ADDR are ignored.
- Drain: when count>0 and drain is permitted (see Configuration), pop the head entry. The next cycle drives oIDX_ADDR/oIDX_DATA with that entry and oIDX_WE=1.
  - At most one pop per cycle.
  - Entries leave in strict FIFO order.
- Status word layout:
  - [31:16] drop_cnt
  - [15] ovf
  - [14] full
  - [13] empty
  - [12:5] 0
  - [4:0] count
- Read: every cycle, oMEM_RDATA <= (iMEM_ADDR==STATUS_ADDR) ? status : 32'h0. Status is sampled before the current cycle's push/pop.
- States: none beyond FIFO occupancy. Behaviour is fully defined by count, ovf and drop_cnt.

## Timing
- Reset values: oMEM_RDATA=0, oIDX_ADDR=0, oIDX_DATA=0, oIDX_WE=0, oFULL=0. Also count=0, drop_cnt=0, ovf=0, pointers=0.
- Store at edge N lands in the FIFO at N+1. oIDX_WE rises at N+2 at the earliest (empty FIFO, drain permitted).
- Sustained throughput is one pixel per cycle while drain is permitted.
- Push when empty plus a drain request in the same cycle: no pop that cycle, because the entry is not yet visible.
- Full plus a simultaneous push and pop: push accepted, count unchanged, no drop.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- iBLANK_n rising while entries remain: draining stops the next cycle. The entry already popped is still written.
- iRST mid-burst: FIFO contents are discarded, oIDX_WE deasserts immediately (asynchronously), and no partial write follows.

## Configuration
- VGA_IDX_BLANK_ONLY_EN defined: drain is permitted only while iBLANK_n=0.
- Undefined: drain is permitted every cycle regardless of iBLANK_n. iBLANK_n is unused and tearing is allowed.

## Structure
- Package vga_idx_pkg holds:
  - FB_WORDS default
  - status bit positions (STAT_DROP_LSB=16, STAT_OVF=15, STAT_FULL=14, STAT_EMPTY=13)
  - a typedef for the {addr,data} FIFO entry
- One sub-module, idx_sync_fifo: single-clock, DEPTH-entry, count-based full/empty, push-with-pop-when-full supported.
- This block contains only the address decode, drop/status logic, drain gating and output registers.

## Test plan
- Reset, then store 8'h2A to FB_BASE+5 with iBLANK_n=0 -> oIDX_WE=1 two cycles later, with oIDX_ADDR=5 and oIDX_DATA=8'h2A.
- Macro defined, iBLANK_n=1, 3 stores -> no oIDX_WE. Drop iBLANK_n to 0 -> three consecutive oIDX_WE pulses, in order.
- iBLANK_n=1, 18 stores with DEPTH=16 -> oFULL=1, and a status read returns drop_cnt=2, ovf=1, count=16.
- Store 1 to STATUS_ADDR -> the next status read shows drop_cnt=0 and ovf=0, with count unchanged.
- FIFO full while draining, with a store every cycle for 40 cycles -> zero drops and 40 index writes.
- Store to FB_BASE+FB_WORDS and to FB_BASE-1 -> no push and count stays 0. Assert iRST with 5 entries queued -> no further oIDX_WE after release.
